// File: rtl/residual_skip_aligner.sv
//------------------------------------------------------------------------------
// Module  : residual_skip_aligner
// Brief   : Skip-path FIFO that pairs residual elements with main-path elements
//           in order, tracking the vector position. Optional sticky error flags
//           are built when RESIDUAL_ALIGN_ERR_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module residual_skip_aligner #(
  parameter int IDATA_WIDTH = 8,
  parameter int DEPTH       = 16,
  parameter int VEC_LEN     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [IDATA_WIDTH-1:0]     skip_data,
  input  logic                       skip_vld,
  output logic                       skip_rdy,
  input  logic [IDATA_WIDTH-1:0]     main_data,
  input  logic                       main_vld,
  output logic                       main_rdy,
  output logic [IDATA_WIDTH-1:0]     out_data_a,
  output logic [IDATA_WIDTH-1:0]     out_data_b,
  output logic                       out_data_vld,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       err_ovf,
  output logic                       err_udf
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ELEM_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [CNT_W-1:0]  C_FULL      = CNT_W'(DEPTH);
  localparam logic [ELEM_W-1:0] C_ELEM_LAST = ELEM_W'(VEC_LEN - 1);

  logic [IDATA_WIDTH-1:0] fifo_mem [DEPTH];

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ELEM_W-1:0]      elem_q, elem_d;
  logic [IDATA_WIDTH-1:0] out_data_a_q, out_data_a_d;
  logic [IDATA_WIDTH-1:0] out_data_b_q, out_data_b_d;
  logic                   out_data_vld_q, out_data_vld_d;
  logic                   out_last_q, out_last_d;
  logic                   push, pop;

  always_comb begin
    // Readiness depends only on registered occupancy and flush, never on the valids.
    skip_rdy       = (cnt_q != C_FULL) && !flush;
    main_rdy       = (cnt_q != '0) && !flush;
    push           = skip_vld && skip_rdy;
    pop            = main_vld && main_rdy;

    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    elem_d         = elem_q;
    out_data_a_d   = out_data_a_q;
    out_data_b_d   = out_data_b_q;
    out_data_vld_d = 1'b0;
    out_last_d     = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      elem_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d       = rd_ptr_q + PTR_W'(1);
        out_data_a_d   = main_data;
        out_data_b_d   = fifo_mem[rd_ptr_q];
        out_data_vld_d = 1'b1;
        out_last_d     = (elem_q == C_ELEM_LAST);
        elem_d         = (elem_q == C_ELEM_LAST) ? '0 : elem_q + ELEM_W'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      elem_q         <= '0;
      out_data_a_q   <= '0;
      out_data_b_q   <= '0;
      out_data_vld_q <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      elem_q         <= elem_d;
      out_data_a_q   <= out_data_a_d;
      out_data_b_q   <= out_data_b_d;
      out_data_vld_q <= out_data_vld_d;
      out_last_q     <= out_last_d;
    end
  end

  // Storage is intentionally unreset; entries are only read while cnt > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= skip_data;
    end
  end

  assign out_data_a   = out_data_a_q;
  assign out_data_b   = out_data_b_q;
  assign out_data_vld = out_data_vld_q;
  assign out_last     = out_last_q;
  assign fifo_cnt     = cnt_q;

`ifdef RESIDUAL_ALIGN_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (skip_vld && !skip_rdy && !flush);
    err_udf_d = err_udf_q | (main_vld && (cnt_q == '0) && !flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_residual_skip_aligner.sv
//------------------------------------------------------------------------------
// Module  : tb_residual_skip_aligner
// Brief   : Directed self-checking bench for residual_skip_aligner (VEC_LEN=4).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_residual_skip_aligner;

  localparam int W = 8;
  localparam int D = 16;
  localparam int V = 4;
`ifdef RESIDUAL_ALIGN_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [W-1:0] skip_data;
  logic         skip_vld;
  logic         skip_rdy;
  logic [W-1:0] main_data;
  logic         main_vld;
  logic         main_rdy;
  logic [W-1:0] out_data_a;
  logic [W-1:0] out_data_b;
  logic         out_data_vld;
  logic         out_last;
  logic [4:0]   fifo_cnt;
  logic         err_ovf;
  logic         err_udf;

  int           n_cmp = 0;
  int           n_err = 0;
  int           pc    = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] v;
  logic [W-1:0] eb;

  residual_skip_aligner #(
    .IDATA_WIDTH(W),
    .DEPTH      (D),
    .VEC_LEN    (V)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .skip_data   (skip_data),
    .skip_vld    (skip_vld),
    .skip_rdy    (skip_rdy),
    .main_data   (main_data),
    .main_vld    (main_vld),
    .main_rdy    (main_rdy),
    .out_data_a  (out_data_a),
    .out_data_b  (out_data_b),
    .out_data_vld(out_data_vld),
    .out_last    (out_last),
    .fifo_cnt    (fifo_cnt),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pair seen at this negedge; last flag expected on every V-th pair since the last flush.
  task automatic pair_check(input logic [W-1:0] ea, input logic [W-1:0] exb);
    check("pair_vld", 32'(out_data_vld), 32'd1);
    check("pair_a", 32'(out_data_a), 32'(ea));
    check("pair_b", 32'(out_data_b), 32'(exb));
    check("pair_last", 32'(out_last), 32'((pc % V) == V - 1));
    pc++;
  endtask

  task automatic push(input logic [W-1:0] d);
    skip_vld  = 1'b1;
    skip_data = d;
    q.push_back(d);
    @(negedge clk);
    skip_vld  = 1'b0;
  endtask

  task automatic pop(input logic [W-1:0] m);
    logic [W-1:0] hb;
    main_vld  = 1'b1;
    main_data = m;
    @(negedge clk);
    main_vld  = 1'b0;
    hb = q.pop_front();
    pair_check(m, hb);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; skip_vld = 1'b0; main_vld = 1'b0;
    skip_data = '0; main_data = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 32'(out_data_vld), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_a", 32'(out_data_a), 32'd0);
    check("rst_b", 32'(out_data_b), 32'd0);
    check("rst_skip_rdy", 32'(skip_rdy), 32'd1);
    check("rst_main_rdy", 32'(main_rdy), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_ovf", 32'(err_ovf), 32'd0);
    check("rst_udf", 32'(err_udf), 32'd0);

    // Basic pairing
    push(8'd1); push(8'd4); push(8'd25); push(8'hE7);
    check("basic_cnt4", 32'(fifo_cnt), 32'd4);
    pop(8'd1); pop(8'd2); pop(8'd4); pop(8'hFC);
    check("basic_cnt0", 32'(fifo_cnt), 32'd0);
    @(negedge clk);
    check("basic_idle_vld", 32'(out_data_vld), 32'd0);
    check("basic_idle_last", 32'(out_last), 32'd0);

    // Fill to full
    for (int k = 0; k < 16; k++) push(8'(k * 7 + 3));
    check("full_skip_rdy", 32'(skip_rdy), 32'd0);
    check("full_cnt", 32'(fifo_cnt), 32'd16);
    check("full_main_rdy", 32'(main_rdy), 32'd1);

    // Pop while full with a push offered: push must be refused
    skip_vld = 1'b1; skip_data = 8'h55; main_vld = 1'b1; main_data = 8'h11;
    @(negedge clk);
    skip_vld = 1'b0; main_vld = 1'b0;
    eb = q.pop_front();
    pair_check(8'h11, eb);
    check("full_refuse_cnt", 32'(fifo_cnt), 32'd15);
    check("full_refuse_rdy", 32'(skip_rdy), 32'd1);

    // Interleaved push/pop across the pointer wrap
    for (int k = 0; k < 20; k++) begin
      v = 8'(k * 11 + 50);
      skip_vld = 1'b1; skip_data = v; main_vld = 1'b1; main_data = 8'(k);
      @(negedge clk);
      skip_vld = 1'b0; main_vld = 1'b0;
      eb = q.pop_front();
      pair_check(8'(k), eb);
      q.push_back(v);
    end
    check("wrap_cnt", 32'(fifo_cnt), 32'd15);
    for (int k = 0; k < 15; k++) pop(8'(k + 30));
    check("drain_cnt", 32'(fifo_cnt), 32'd0);

    // Flush with cnt = 5 and elem mid-vector
    for (int k = 0; k < 7; k++) push(8'(k + 60));
    pop(8'h70); pop(8'h71);
    check("flush_pre_cnt", 32'(fifo_cnt), 32'd5);
    flush = 1'b1; main_vld = 1'b1; main_data = 8'h77;
    #1;
    check("flush_main_rdy", 32'(main_rdy), 32'd0);
    check("flush_skip_rdy", 32'(skip_rdy), 32'd0);
    @(negedge clk);
    flush = 1'b0; main_vld = 1'b0;
    check("flush_vld", 32'(out_data_vld), 32'd0);
    check("flush_cnt", 32'(fifo_cnt), 32'd0);
    q.delete();
    pc = 0;

    // Last flag: 9 pairs, last on pairs 4 and 8
    for (int k = 0; k < 9; k++) push(8'(k + 90));
    for (int k = 0; k < 9; k++) pop(8'(k + 1));
    check("last_cnt", 32'(fifo_cnt), 32'd0);

    // Error flags: main while empty, no fall-through from a same-cycle push
    skip_vld = 1'b1; skip_data = 8'h42; main_vld = 1'b1; main_data = 8'h24;
    @(negedge clk);
    skip_vld = 1'b0; main_vld = 1'b0;
    q.push_back(8'h42);
    check("nofall_vld", 32'(out_data_vld), 32'd0);
    check("nofall_cnt", 32'(fifo_cnt), 32'd1);
    check("udf_set", 32'(err_udf), 32'(ERR));
    pop(8'h24);
    check("udf_sticky", 32'(err_udf), 32'(ERR));
    check("ovf_clear", 32'(err_ovf), 32'd0);
    for (int k = 0; k < 16; k++) push(8'(k + 120));
    skip_vld = 1'b1; skip_data = 8'h99;
    @(negedge clk);
    skip_vld = 1'b0;
    check("ovf_cnt", 32'(fifo_cnt), 32'd16);
    check("ovf_set", 32'(err_ovf), 32'(ERR));
    check("udf_still", 32'(err_udf), 32'(ERR));

    // Asynchronous reset while a pair is on the outputs
    main_vld = 1'b1; main_data = 8'h01;
    @(posedge clk);
    #1;
    check("arst_pre_vld", 32'(out_data_vld), 32'd1);
    main_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_vld", 32'(out_data_vld), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    check("arst_cnt", 32'(fifo_cnt), 32'd0);
    check("arst_ovf", 32'(err_ovf), 32'd0);
    check("arst_udf", 32'(err_udf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
